// File: rtl/serial_addsub_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The controller drives start/sub/a/b; the adder returns busy/done and the registered result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/sub, LSB first: accept on E0, result and done valid after E_WIDTH.
// Start is ignored while busy; DONE overlaps the next accept for back-to-back issue.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] acc_next;

  // Single full-adder slice on the current LSBs
  always_comb begin
    s_bit    = op_a[0] ^ op_b[0] ^ carry;
    c_bit    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    acc_next = {s_bit, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_next;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge
            sum_q  <= acc_next;
            cout_q <= c_bit;
            ovf_q  <= carry ^ c_bit;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            acc    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH 2, 8 and 16 against an arithmetic model.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_sum [17];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(2))  if2 ();
  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sb,
                       input logic [15:0] av, input logic [15:0] bv);
    case (w)
      2: begin if2.start = st; if2.sub = sb; if2.a = av[1:0]; if2.b = bv[1:0]; end
      8: begin if8.start = st; if8.sub = sb; if8.a = av[7:0]; if8.b = bv[7:0]; end
      default: begin if16.start = st; if16.sub = sb; if16.a = av; if16.b = bv; end
    endcase
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic [15:0] sm, output logic co, output logic ov);
    case (w)
      2: begin bz = if2.busy; dn = if2.done; sm = {14'd0, if2.sum}; co = if2.cout; ov = if2.ovf; end
      8: begin bz = if8.busy; dn = if8.done; sm = {8'd0, if8.sum}; co = if8.cout; ov = if8.ovf; end
      default: begin bz = if16.busy; dn = if16.done; sm = if16.sum; co = if16.cout; ov = if16.ovf; end
    endcase
  endtask

  // Reference: plain modular arithmetic, signed overflow from operand/result signs
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sb,
                       output logic [15:0] s, output logic co, output logic ov);
    int unsigned m, x, y, f;
    logic xs, ys, ss;
    m  = (32'd1 << w) - 1;
    x  = {16'd0, av} & m;
    y  = sb ? (~{16'd0, bv} & m) : ({16'd0, bv} & m);
    f  = x + y + {31'd0, sb};
    s  = 16'(f & m);
    co = f[w];
    xs = x[w-1];
    ys = y[w-1];
    ss = f[w-1];
    ov = (xs == ys) && (ss != xs);
  endtask

  task automatic run_op(input string tag, input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic sb, input logic [15:0] es, input logic ec, input logic eo);
    logic bz, dn, co, ov, seen;
    logic [15:0] sm;
    int bc, n;
    @(negedge clk);
    drive(w, 1'b1, sb, av, bv);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    seen = 1'b0;
    bc = 0;
    n = 0;
    while (!seen && n <= w + 4) begin
      sample(w, bz, dn, sm, co, ov);
      if (dn) seen = 1'b1;
      else begin
        if (bz) begin
          bc++;
          check({tag, "_hold"}, {16'd0, sm}, {16'd0, last_sum[w]});
        end
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_busy_cycles"}, bc, w);
    check({tag, "_sum"}, {16'd0, sm}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, co}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ov}, {31'd0, eo});
    last_sum[w] = es;
    @(negedge clk);
    sample(w, bz, dn, sm, co, ov);
    check({tag, "_done_pulse"}, {30'd0, bz, dn}, 32'd0);
  endtask

  initial begin
    logic bz, dn, co, ov;
    logic [15:0] sm, es, av, bv;
    logic ec, eo, sb;
    int t, t1, t2, dc, w;

    for (int i = 0; i < 17; i++) last_sum[i] = '0;
    drive(2, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    sample(8, bz, dn, sm, co, ov);
    check("reset_w8", {12'd0, bz, dn, co, ov, sm}, 32'd0);
    sample(16, bz, dn, sm, co, ov);
    check("reset_w16", {12'd0, bz, dn, co, ov, sm}, 32'd0);
    // start held during reset must not be accepted
    drive(8, 1'b1, 1'b0, 16'h12, 16'h34);
    @(negedge clk);
    sample(8, bz, dn, sm, co, ov);
    check("reset_priority", {31'd0, bz}, 32'd0);
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    rst_n = 1'b1;

    run_op("add_ovf",  8, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1);
    run_op("add_wrap", 8, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0);
    run_op("sub_brw",  8, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0, 1'b0);
    run_op("sub_ovf",  8, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1);

    // start pulsed in RUN cycle 3 must be ignored
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 16'h11, 16'h22);
    dc = 0;
    es = 16'hDEAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      if (i == 2) drive(8, 1'b1, 1'b0, 16'hFF, 16'hFF);
      if (i == 3) drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      sample(8, bz, dn, sm, co, ov);
      if (dn) begin dc++; es = sm; end
    end
    check("busy_start_done_count", dc, 1);
    check("busy_start_sum", {16'd0, es}, 32'h33);
    last_sum[8] = 16'h33;

    // back-to-back with start held high
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 16'h01, 16'h01);
    t = 0; t1 = -1; t2 = -1;
    while (t < 40 && t2 < 0) begin
      @(negedge clk);
      t++;
      sample(8, bz, dn, sm, co, ov);
      if (dn) begin
        if (t1 < 0) begin
          t1 = t;
          check("b2b_first_sum", {16'd0, sm}, 32'h02);
          drive(8, 1'b1, 1'b0, 16'h7F, 16'h01);
        end else begin
          t2 = t;
          check("b2b_second_sum", {16'd0, sm}, 32'h80);
          check("b2b_second_ovf", {31'd0, ov}, 32'd1);
        end
      end
      if (t1 >= 0 && t == t1 + 1) begin
        check("b2b_no_idle", {31'd0, bz}, 32'd1);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      end
    end
    check("b2b_both_done", {30'd0, t1 >= 0, t2 >= 0}, 32'd3);
    check("b2b_spacing", t2 - t1, 9);
    last_sum[8] = 16'h80;
    repeat (2) @(negedge clk);

    // reset in RUN cycle 4 aborts with no done
    drive(8, 1'b1, 1'b0, 16'h5A, 16'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
      if (i == 3) rst_n = 1'b0;
    end
    @(negedge clk);
    sample(8, bz, dn, sm, co, ov);
    check("midrst_clear", {12'd0, bz, dn, co, ov, sm}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) last_sum[i] = '0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(8, bz, dn, sm, co, ov);
      if (dn || bz) dc++;
    end
    check("midrst_no_done", dc, 0);
    run_op("after_rst", 8, 16'h03, 16'h04, 1'b0, 16'h07, 1'b0, 1'b0);

    run_op("w2_wrap",  2,  16'h0003, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("w16_ff",   16, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("w16_wrap", 16, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("w2_sub",   2,  16'h0002, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b1);

    for (int k = 0; k < 30; k++) begin
      case (k % 3)
        0: w = 2;
        1: w = 8;
        default: w = 16;
      endcase
      av = 16'($urandom);
      bv = 16'($urandom);
      sb = 1'($urandom);
      model(w, av, bv, sb, es, ec, eo);
      run_op("rand", w, av, bv, sb, es, ec, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
